tx_packet_framer: RTL and testbench
===================================

TX_PACKET_FRAMER -- requirements
Module: tx_packet_framer

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, n_rst.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 tx_packet  input  3  packet request: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 reserved (ignored).
REQ-005 buffer_occupancy  input  7  byte count from the data buffer, sampled at packet start.
REQ-006 tx_packet_data  input  8  byte from the data buffer, valid the cycle after get_tx_packet_data.
REQ-007 get_tx_packet_data  output  1  one-cycle pop strobe to the data buffer.
REQ-008 byte_out  output  8  byte to the bit serializer, LSB transmitted first.
REQ-009 byte_valid  output  1  byte_out holds a byte for the serializer.
REQ-010 byte_ready  input  1  serializer accepts byte_out on a rising edge when byte_valid=1.
REQ-011 tx_transfer_active  output  1  high whenever the FSM is not IDLE.
REQ-012 packet_done  output  1  one-cycle pulse after the last byte is accepted.
REQ-013 tx_error  output  1  one-cycle pulse on rejected request.

Function
REQ-014 FSM states SHALL be IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, DONE.
REQ-015 In IDLE, tx_packet in 1-5 SHALL latch request and occupancy and go to SYNC next cycle; 0/6/7 SHALL remain IDLE.
REQ-016 A DATA0/DATA1 request with buffer_occupancy > 64 SHALL pulse tx_error, send nothing, remain IDLE.
REQ-017 SYNC SHALL present byte_out=0x80 with byte_valid=1 until accepted, then go to PID.
REQ-018 PID byte SHALL be {~pid,pid}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
REQ-019 After PID accept: handshake packets (ACK/NAK/STALL) go to DONE; data packets go to FETCH if count>0, else CRC_LO.
REQ-020 FETCH SHALL assert get_tx_packet_data for exactly one cycle, then LOAD.
REQ-021 LOAD SHALL capture tx_packet_data into the byte register, update CRC, decrement count, go to DATA.
REQ-022 DATA SHALL hold byte_valid=1; on accept go to FETCH if count>0, else CRC_LO.
REQ-023 CRC SHALL be CRC-16/USB: poly 0x8005 reflected (0xA001), init 0xFFFF, LSB-first per byte, final XOR 0xFFFF.
REQ-024 CRC_LO SHALL send inverted CRC[7:0], CRC_HI inverted CRC[15:8], each held until accepted.
REQ-025 DONE SHALL pulse packet_done for one cycle and return to IDLE.
REQ-026 byte_out SHALL stay stable while byte_valid=1 and byte_ready=0; byte_valid SHALL be 0 in IDLE, FETCH, LOAD, DONE.
REQ-027 tx_packet changes while not IDLE SHALL be ignored; a new request is sampled only in IDLE.
REQ-028 Zero-length data packet SHALL send SYNC, PID, 0x00, 0x00.
REQ-029 get_tx_packet_data SHALL pulse exactly occupancy times per data packet, never for handshake packets.

Reset
REQ-030 n_rst=0 SHALL immediately force IDLE, byte_out=0x00, byte_valid=0, get_tx_packet_data=0, tx_transfer_active=0, packet_done=0, tx_error=0, CRC=0xFFFF, count=0.
REQ-031 Reset mid-packet SHALL abandon the packet; no further pops or bytes until a new request after release.

Verification
REQ-032 tx_packet=3, byte_ready=1 -> bytes 0x80, 0xD2; packet_done pulse; zero pops.
REQ-033 tx_packet=1, occupancy=0 -> bytes 0x80, 0xC3, 0x00, 0x00; zero pops.
REQ-034 tx_packet=2, occupancy=9, buffer "123456789" (0x31..0x39) -> 0x80, 0x4B, 0x31..0x39, 0xC8, 0xB4; nine pops.
REQ-035 byte_ready low 3 cycles during PID of DATA0 -> byte_out held 0xC3, byte_valid high, no pop until accept.
REQ-036 tx_packet=1, occupancy=70 -> tx_error pulse, tx_transfer_active stays 0, no bytes.
REQ-037 n_rst low during DATA state of 4-byte packet -> all outputs zero same cycle; next ACK request framed correctly.

Source files
------------

// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - USB-style transmit packet framer (SYNC, PID, payload, CRC-16)
//
// Purpose: turns a packet request into a byte stream for a bit serializer.
// Data packets pop their payload from an external buffer and end with an
// inverted CRC-16/USB. Handshake packets carry only SYNC and PID.
//
// Ports:
//   clk                 system clock, rising edge
//   n_rst               asynchronous active-low reset
//   tx_packet[2:0]      request: 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, others ignored
//   buffer_occupancy    payload byte count, sampled when a request starts
//   tx_packet_data      payload byte, valid the cycle after get_tx_packet_data
//   get_tx_packet_data  one-cycle pop strobe to the data buffer
//   byte_out            byte to the serializer, LSB first
//   byte_valid          byte_out holds a byte for the serializer
//   byte_ready          serializer accepts byte_out on a rising edge when byte_valid=1
//   tx_transfer_active  high whenever a packet is in progress
//   packet_done         one-cycle pulse after the last byte is accepted
//   tx_error            one-cycle pulse when a data request exceeds 64 bytes
module tx_packet_framer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       tx_transfer_active,
  output logic       packet_done,
  output logic       tx_error
);

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  pid_q;
  logic [6:0]  count_q;
  logic [15:0] crc_q;
  logic [7:0]  data_q;
  logic        error_q;

  logic        req_valid;
  logic        req_is_data;
  logic        reject;
  logic        start;
  logic        is_handshake;
  logic [7:0]  pid_byte;

  // Reflected CRC-16 update, one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign req_valid    = (state == IDLE) && (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
  assign req_is_data  = (tx_packet == 3'd1) || (tx_packet == 3'd2);
  assign reject       = req_valid && req_is_data && (buffer_occupancy > 7'd64);
  assign start        = req_valid && !reject;
  assign is_handshake = (pid_q >= 3'd3);

  always_comb begin
    pid_byte = 8'h00;
    case (pid_q)
      3'd1:    pid_byte = 8'hC3;
      3'd2:    pid_byte = 8'h4B;
      3'd3:    pid_byte = 8'hD2;
      3'd4:    pid_byte = 8'h5A;
      3'd5:    pid_byte = 8'h1E;
      default: pid_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      pid_q   <= 3'd0;
      count_q <= 7'd0;
      crc_q   <= 16'hFFFF;
      data_q  <= 8'h00;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      error_q <= reject;
      if (start) begin
        pid_q   <= tx_packet;
        count_q <= buffer_occupancy;
        crc_q   <= 16'hFFFF;
      end
      if (state == LOAD) begin
        data_q  <= tx_packet_data;
        crc_q   <= crc16_byte(crc_q, tx_packet_data);
        count_q <= count_q - 7'd1;
      end
    end
  end

  // byte_out is decoded from state and held registers, so it cannot move
  // while the FSM waits for byte_ready.
  always_comb begin
    state_nxt          = state;
    byte_out           = 8'h00;
    byte_valid         = 1'b0;
    get_tx_packet_data = 1'b0;
    packet_done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SYNC;
      end
      SYNC: begin
        byte_out   = 8'h80;
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = PID;
      end
      PID: begin
        byte_out   = pid_byte;
        byte_valid = 1'b1;
        if (byte_ready) begin
          if (is_handshake)          state_nxt = DONE;
          else if (count_q != 7'd0)  state_nxt = FETCH;
          else                       state_nxt = CRC_LO;
        end
      end
      FETCH: begin
        get_tx_packet_data = 1'b1;
        state_nxt          = LOAD;
      end
      LOAD: begin
        state_nxt = DATA;
      end
      DATA: begin
        byte_out   = data_q;
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = (count_q != 7'd0) ? FETCH : CRC_LO;
      end
      CRC_LO: begin
        byte_out   = ~crc_q[7:0];
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = CRC_HI;
      end
      CRC_HI: begin
        byte_out   = ~crc_q[15:8];
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = DONE;
      end
      DONE: begin
        packet_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_transfer_active = (state != IDLE);
  assign tx_error           = error_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb/tb_tx_packet_framer.sv - directed self-checking bench for tx_packet_framer
module tb_tx_packet_framer;

  logic       clk;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       tx_transfer_active;
  logic       packet_done;
  logic       tx_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  logic [7:0] got [$];
  int pops_total   = 0;
  int done_total   = 0;
  int error_total  = 0;
  int active_total = 0;
  int pop_base     = 0;

  tx_packet_framer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .tx_transfer_active (tx_transfer_active),
    .packet_done        (packet_done),
    .tx_error           (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor and buffer model, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) got.push_back(byte_out);
    if (packet_done) done_total++;
    if (tx_error) error_total++;
    if (tx_transfer_active) active_total++;
    if (get_tx_packet_data) begin
      tx_packet_data = mem[6'((pops_total - pop_base) & 63)];
      pops_total++;
    end
  end

  task automatic send_req(input logic [2:0] pkt, input logic [6:0] occ);
    @(posedge clk); #1;
    tx_packet        = pkt;
    buffer_occupancy = occ;
    @(posedge clk); #1;
    tx_packet        = 3'd0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({byte_out, byte_valid, get_tx_packet_data, tx_transfer_active, packet_done, tx_error} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {byte_out, byte_valid, get_tx_packet_data, tx_transfer_active, packet_done, tx_error});
    end
    wait_cycles(2);
    n_rst = 1'b1;
    wait_cycles(2);
    checks++;
    if (tx_transfer_active !== 1'b0 || got.size() != 0) begin
      errors++;
      $display("FAIL reset_idle active=%b bytes=%0d want 0/0", tx_transfer_active, got.size());
    end
  endtask

  task automatic test_ack;
    int base, pb, db;
    base = got.size(); pb = pops_total; db = done_total;
    byte_ready = 1'b1;
    send_req(3'd3, 7'd5);
    wait_cycles(15);
    checks++;
    if (got.size() - base != 2) begin
      errors++; $display("FAIL ack_len got=%0d want=2", got.size() - base);
    end else begin
      checks++;
      if (got[base] !== 8'h80 || got[base+1] !== 8'hD2) begin
        errors++; $display("FAIL ack_bytes got=%h %h want=80 d2", got[base], got[base+1]);
      end
    end
    checks++;
    if (done_total - db != 1) begin
      errors++; $display("FAIL ack_done got=%0d want=1", done_total - db);
    end
    checks++;
    if (pops_total != pb) begin
      errors++; $display("FAIL ack_pops got=%0d want=0", pops_total - pb);
    end
  endtask

  task automatic test_zero_len;
    int base, pb;
    logic [7:0] exp [4];
    exp = '{8'h80, 8'hC3, 8'h00, 8'h00};
    base = got.size(); pb = pops_total;
    byte_ready = 1'b1;
    send_req(3'd1, 7'd0);
    wait_cycles(15);
    checks++;
    if (got.size() - base != 4) begin
      errors++; $display("FAIL zero_len_len got=%0d want=4", got.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[base+i] !== exp[i]) begin
          errors++; $display("FAIL zero_len_byte%0d got=%h want=%h", i, got[base+i], exp[i]);
        end
      end
    end
    checks++;
    if (pops_total != pb) begin
      errors++; $display("FAIL zero_len_pops got=%0d want=0", pops_total - pb);
    end
  endtask

  task automatic test_crc_check_string;
    int base;
    logic [7:0] exp [13];
    exp = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
            8'h38, 8'h39, 8'hC8, 8'hB4};
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    pop_base = pops_total;
    base = got.size();
    byte_ready = 1'b1;
    send_req(3'd2, 7'd9);
    wait_cycles(50);
    checks++;
    if (got.size() - base != 13) begin
      errors++; $display("FAIL crc_len got=%0d want=13", got.size() - base);
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (got[base+i] !== exp[i]) begin
          errors++; $display("FAIL crc_byte%0d got=%h want=%h", i, got[base+i], exp[i]);
        end
      end
    end
    checks++;
    if (pops_total - pop_base != 9) begin
      errors++; $display("FAIL crc_pops got=%0d want=9", pops_total - pop_base);
    end
  endtask

  task automatic test_backpressure;
    int base;
    bit found;
    mem[0] = 8'hAA;
    pop_base = pops_total;
    base = got.size();
    byte_ready = 1'b0;
    send_req(3'd1, 7'd1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (byte_valid && byte_out == 8'h80) found = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL bp_sync_timeout got=none want=80");
    end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (byte_out !== 8'hC3 || byte_valid !== 1'b1 || pops_total != pop_base) begin
        errors++;
        $display("FAIL bp_hold%0d byte=%h valid=%b pops=%0d want c3/1/0", i, byte_out, byte_valid, pops_total - pop_base);
      end
    end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_cycles(15);
    checks++;
    if (got.size() - base != 5 || got[base] !== 8'h80 || got[base+1] !== 8'hC3 || got[base+2] !== 8'hAA) begin
      errors++; $display("FAIL bp_stream len=%0d want=5 with 80 c3 aa", got.size() - base);
    end
    checks++;
    if (pops_total - pop_base != 1) begin
      errors++; $display("FAIL bp_pops got=%0d want=1", pops_total - pop_base);
    end
  endtask

  task automatic test_reject;
    int base, eb, ab;
    base = got.size(); eb = error_total; ab = active_total;
    byte_ready = 1'b1;
    send_req(3'd1, 7'd70);
    wait_cycles(10);
    checks++;
    if (error_total - eb != 1) begin
      errors++; $display("FAIL reject_error got=%0d want=1", error_total - eb);
    end
    checks++;
    if (active_total != ab || got.size() != base) begin
      errors++; $display("FAIL reject_idle active=%0d bytes=%0d want 0/0", active_total - ab, got.size() - base);
    end
  endtask

  task automatic test_max_len;
    int base, eb;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    pop_base = pops_total;
    base = got.size(); eb = error_total;
    byte_ready = 1'b1;
    send_req(3'd2, 7'd64);
    wait_cycles(250);
    checks++;
    if (error_total != eb || pops_total - pop_base != 64 || got.size() - base != 68) begin
      errors++;
      $display("FAIL max_len err=%0d pops=%0d bytes=%0d want 0/64/68", error_total - eb, pops_total - pop_base, got.size() - base);
    end
    checks++;
    if (got.size() - base == 68 && got[base+65] !== 8'h3F) begin
      errors++; $display("FAIL max_len_last got=%h want=3f", got[base+65]);
    end
  endtask

  task automatic test_reset_mid_packet;
    int base, pb;
    bit found;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    pop_base = pops_total;
    byte_ready = 1'b1;
    send_req(3'd1, 7'd4);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (byte_valid && byte_out == 8'h11) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_mid_timeout got=none want=11");
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({byte_out, byte_valid, get_tx_packet_data, tx_transfer_active, packet_done, tx_error} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%h want=0", {byte_out, byte_valid, get_tx_packet_data, tx_transfer_active, packet_done, tx_error});
    end
    base = got.size(); pb = pops_total;
    wait_cycles(3);
    n_rst = 1'b1;
    wait_cycles(10);
    checks++;
    if (got.size() != base || pops_total != pb || tx_transfer_active !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet bytes=%0d pops=%0d active=%b want 0/0/0", got.size() - base, pops_total - pb, tx_transfer_active);
    end
    send_req(3'd3, 7'd0);
    wait_cycles(15);
    checks++;
    if (got.size() - base != 2 || got[base] !== 8'h80 || got[base+1] !== 8'hD2) begin
      errors++; $display("FAIL rst_mid_ack len=%0d want=2 with 80 d2", got.size() - base);
    end
  endtask

  initial begin
    n_rst            = 1'b0;
    tx_packet        = 3'd0;
    buffer_occupancy = 7'd0;
    tx_packet_data   = 8'h00;
    byte_ready       = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset;
    test_ack;
    test_zero_len;
    test_crc_check_string;
    test_backpressure;
    test_reject;
    test_max_len;
    test_reset_mid_packet;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
